risc16_exec_store: RTL and testbench
====================================

Name: risc16_exec_store

Overview:
- Execute/storage back end of the 16-bit RISC datapath, merging three functions in one block: ALU control decode, the 8x16 general-purpose register file, and the word-organised data memory.
- Sits between the main control unit and instruction decode on one side, and the ALU and write-back mux on the other.
- All reads are combinational. All writes occur on the rising clock edge.

Parameters:
- DMEM_AW, 3, log2 of data-memory depth in 16-bit words (default 8 words).
- REG_AW, 3, register address width (8 registers); fixed at 3, exposed for documentation only.

Ports:
- clk  in  1  system clock; all writes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- alu_op  in  2  ALU operation class from main control
- opcode  in  4  instr[15:12]
- alu_sel  out  3  ALU function select
- reg_write  in  1  register-file write enable
- wr_addr  in  3  register write address
- wr_data  in  16  register write data
- rd_addr_1  in  3  read port 1 address (instr[11:9])
- rd_data_1  out  16  read port 1 data
- rd_addr_2  in  3  read port 2 address (instr[8:6])
- rd_data_2  out  16  read port 2 data
- mem_addr  in  16  byte address (ALU result)
- mem_wdata  in  16  store data
- mem_we  in  1  memory write enable
- mem_re  in  1  memory read enable
- mem_rdata  out  16  load data

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous, active-low.
  - While rst_n=0, all 8 registers and all 2^DMEM_AW memory words are held at 16'h0000.
  - Writes presented while in reset are ignored.
  - Reset asserted mid-write wins: the cell reads 0.
- ALU control (combinational), alu_sel encoding: 000 add, 001 sub, 010 not a, 011 shl, 100 shr, 101 and, 110 or, 111 slt.
  - alu_op=10 -> 000 (load/store address add).
  - alu_op=01 -> 001 (beq/bne compare).
  - alu_op=11 -> 000 (immediate add).
  - alu_op=00 -> decode opcode: 0010->000, 0011->001, 0100->010, 0101->011, 0110->100, 0111->101, 1000->110, 1001->111.
  - Any other opcode with alu_op=00 -> 000.
- Register file:
  - rd_data_n = reg[rd_addr_n], combinational, zero latency.
  - On rising edge with reg_write=1 and rst_n=1: reg[wr_addr] <= wr_data.
  - No write-to-read bypass: a read of the address being written returns the old value until after the edge.
  - Both read ports may address the same register.
- Data memory:
  - Word index = mem_addr[DMEM_AW:1]. mem_addr[0] and bits above DMEM_AW are ignored, so addresses wrap modulo 2^(DMEM_AW+1) bytes.
  - On rising edge with mem_we=1 and rst_n=1: mem[index] <= mem_wdata.
  - mem_rdata = mem_re ? mem[index] : 16'h0000, combinational.
  - mem_we=mem_re=1 in the same cycle: mem_rdata shows the old word before the edge and the new word after it.
- Outputs after reset: rd_data_1 = rd_data_2 = mem_rdata = 0; alu_sel follows its inputs.

Optional Feature:
- Macro GPR_R0_ZERO_EN.
- Defined: register 0 is hardwired to zero; reads of address 0 return 16'h0000 and writes to it are discarded.
- Undefined: register 0 is an ordinary writable register.

Test Plan:
- Reset: drive rst_n=0 mid-cycle, sweep rd_addr_1/2 over 0..7 and mem_addr over 0,2..14 with mem_re=1 -> all reads 16'h0000 immediately, with no clock edge.
- ALU decode: alu_op=00 with opcode 0010..1001 -> alu_sel 000..111. alu_op=01, opcode=1011 -> 001. alu_op=10 -> 000. alu_op=00, opcode=1111 -> 000.
- Register write and read:
  - reg_write=1, wr_addr=5, wr_data=16'hA5A5 -> rd_data_1 at addr 5 reads old 0 before the edge and A5A5 after it.
  - reg_write=0 with a different value -> register unchanged.
  - Write 16'h1234 to addr 0 -> reads 1234, or 0000 with GPR_R0_ZERO_EN defined.
- Memory store/load:
  - mem_we=1, mem_addr=16'h0006, mem_wdata=16'hBEEF -> later mem_re=1 at 16'h0006 gives BEEF.
  - Address 16'h0007 also gives BEEF (bit 0 ignored).
  - Address 16'h0016 also gives BEEF (wrap, DMEM_AW=3).
  - mem_re=0 -> mem_rdata = 0000.
- Simultaneous access: mem_we=mem_re=1 at the same address with new data 16'h0F0F -> old value before the edge, 0F0F after it.
- Reset during operation: fill registers and memory with nonzero values, then pulse rst_n low -> all cleared asynchronously. A write held asserted during reset has no effect.

Source files
------------

// File: rtl/risc16_exec_store.sv
// Execute/storage back end of the 16-bit RISC datapath: ALU control decode, 8x16 register file
// and word-organised data memory. Optional macro GPR_R0_ZERO_EN hardwires register 0 to zero.
module risc16_exec_store #(
  parameter int DMEM_AW = 3,
  parameter int REG_AW  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         alu_op,
  input  logic [3:0]         opcode,
  output logic [2:0]         alu_sel,
  input  logic               reg_write,
  input  logic [REG_AW-1:0]  wr_addr,
  input  logic [15:0]        wr_data,
  input  logic [REG_AW-1:0]  rd_addr_1,
  output logic [15:0]        rd_data_1,
  input  logic [REG_AW-1:0]  rd_addr_2,
  output logic [15:0]        rd_data_2,
  input  logic [15:0]        mem_addr,
  input  logic [15:0]        mem_wdata,
  input  logic               mem_we,
  input  logic               mem_re,
  output logic [15:0]        mem_rdata
);

  localparam int NREG  = 1 << REG_AW;
  localparam int DEPTH = 1 << DMEM_AW;

  // ALU control decode
  always_comb begin
    alu_sel = 3'b000;
    case (alu_op)
      2'b01: alu_sel = 3'b001;
      2'b00: begin
        case (opcode)
          4'b0010: alu_sel = 3'b000;
          4'b0011: alu_sel = 3'b001;
          4'b0100: alu_sel = 3'b010;
          4'b0101: alu_sel = 3'b011;
          4'b0110: alu_sel = 3'b100;
          4'b0111: alu_sel = 3'b101;
          4'b1000: alu_sel = 3'b110;
          4'b1001: alu_sel = 3'b111;
          default: alu_sel = 3'b000;
        endcase
      end
      default: alu_sel = 3'b000;
    endcase
  end

  // Register file
  logic [15:0]     gpr_reg [NREG];
  logic [NREG-1:0] gpr_we;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_gpr_we
`ifdef GPR_R0_ZERO_EN
    // Register 0 never accepts a write, so it stays at its reset value of zero.
    if (gi == 0) begin : g_r0
      assign gpr_we[gi] = 1'b0;
    end else begin : g_rn
      assign gpr_we[gi] = reg_write && (wr_addr == REG_AW'(gi));
    end
`else
    assign gpr_we[gi] = reg_write && (wr_addr == REG_AW'(gi));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) gpr_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (gpr_we[i]) gpr_reg[i] <= wr_data;
      end
    end
  end

  assign rd_data_1 = gpr_reg[rd_addr_1];
  assign rd_data_2 = gpr_reg[rd_addr_2];

  // Data memory: byte address, word-indexed; bit 0 and the high bits are dropped.
  logic [15:0]        mem_reg [DEPTH];
  logic [DMEM_AW-1:0] mem_idx;
  logic [DEPTH-1:0]   mem_wen;
  logic               unused_addr_bits;

  assign mem_idx          = mem_addr[DMEM_AW:1];
  assign unused_addr_bits = ^{mem_addr[15:DMEM_AW+1], mem_addr[0]};

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem_we
    assign mem_wen[gi] = mem_we && (mem_idx == DMEM_AW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_wen[i]) mem_reg[i] <= mem_wdata;
      end
    end
  end

  assign mem_rdata = mem_re ? mem_reg[mem_idx] : 16'h0000;

endmodule

// File: tb/tb_risc16_exec_store.sv
// Scoreboard bench for risc16_exec_store: stimulus pushes expected values, a monitor compares them.
`timescale 1ns/1ps
module tb_risc16_exec_store;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  alu_op;
  logic [3:0]  opcode;
  logic [2:0]  alu_sel;
  logic        reg_write;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr_1;
  logic [15:0] rd_data_1;
  logic [2:0]  rd_addr_2;
  logic [15:0] rd_data_2;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  risc16_exec_store #(.DMEM_AW(3), .REG_AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_op(alu_op), .opcode(opcode), .alu_sel(alu_sel),
    .reg_write(reg_write), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1),
    .rd_addr_2(rd_addr_2), .rd_data_2(rd_data_2),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  localparam int SEL_ALU = 0, SEL_RD1 = 1, SEL_RD2 = 2, SEL_MEM = 3;

  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  event check_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef GPR_R0_ZERO_EN
  localparam logic [15:0] R0_EXP = 16'h0000;
`else
  localparam logic [15:0] R0_EXP = 16'h1234;
`endif

  function automatic logic [15:0] pick(int sel);
    case (sel)
      SEL_ALU: return {13'b0, alu_sel};
      SEL_RD1: return rd_data_1;
      SEL_RD2: return rd_data_2;
      default: return mem_rdata;
    endcase
  endfunction

  // Monitor: drains the scoreboard each time the stimulus presents a settled output.
  initial begin : monitor
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(check_ev);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = pick(e.sel);
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h (t=%0t)", e.name, act, e.exp, $time);
        end else begin
          $display("ok   %s: %h (t=%0t)", e.name, act, $time);
        end
      end
    end
  end

  task automatic expect_out(input int sel, input logic [15:0] exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    ->check_ev;
    #1;
  endtask

  // Drive one register and one memory write across a rising edge.
  task automatic write_both(input logic [2:0] ra, input logic [15:0] rd,
                            input logic [15:0] ma, input logic [15:0] md);
    @(negedge clk);
    reg_write = 1'b1; wr_addr = ra; wr_data = rd;
    mem_we = 1'b1; mem_addr = ma; mem_wdata = md;
    @(posedge clk);
    #1;
    reg_write = 1'b0; mem_we = 1'b0;
  endtask

  logic [8:0] alu_vec [12];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int t;
    // {alu_op, opcode, expected alu_sel}
    alu_vec[0]  = {2'b00, 4'b0010, 3'b000};
    alu_vec[1]  = {2'b00, 4'b0011, 3'b001};
    alu_vec[2]  = {2'b00, 4'b0100, 3'b010};
    alu_vec[3]  = {2'b00, 4'b0101, 3'b011};
    alu_vec[4]  = {2'b00, 4'b0110, 3'b100};
    alu_vec[5]  = {2'b00, 4'b0111, 3'b101};
    alu_vec[6]  = {2'b00, 4'b1000, 3'b110};
    alu_vec[7]  = {2'b00, 4'b1001, 3'b111};
    alu_vec[8]  = {2'b01, 4'b1011, 3'b001};
    alu_vec[9]  = {2'b10, 4'b1001, 3'b000};
    alu_vec[10] = {2'b11, 4'b0100, 3'b000};
    alu_vec[11] = {2'b00, 4'b1111, 3'b000};

    rst_n = 1'b1; alu_op = 2'b00; opcode = 4'b0000;
    reg_write = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
    rd_addr_1 = 3'd0; rd_addr_2 = 3'd0;
    mem_addr = 16'h0000; mem_wdata = 16'h0000; mem_we = 1'b0; mem_re = 1'b0;

    // Reset asserted mid-cycle; all reads must be zero
    #2 rst_n = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd_addr_1 = 3'(a); rd_addr_2 = 3'(7 - a); mem_addr = 16'(2 * a); mem_re = 1'b1;
      #1;
      expect_out(SEL_RD1, 16'h0000, $sformatf("reset rd1[%0d]", a));
      expect_out(SEL_RD2, 16'h0000, $sformatf("reset rd2[%0d]", 7 - a));
      expect_out(SEL_MEM, 16'h0000, $sformatf("reset mem[%0d]", 2 * a));
    end
    @(negedge clk);
    rst_n = 1'b1; mem_re = 1'b0;

    // ALU control decode
    for (int i = 0; i < 12; i++) begin
      {alu_op, opcode} = alu_vec[i][8:3];
      #1;
      expect_out(SEL_ALU, {13'b0, alu_vec[i][2:0]},
                 $sformatf("alu op=%b opc=%b", alu_vec[i][8:7], alu_vec[i][6:3]));
    end

    // Register write: old value before the edge, new after
    @(negedge clk);
    reg_write = 1'b1; wr_addr = 3'd5; wr_data = 16'hA5A5; rd_addr_1 = 3'd5; rd_addr_2 = 3'd5;
    #1;
    expect_out(SEL_RD1, 16'h0000, "reg5 before edge");
    @(posedge clk); #1;
    expect_out(SEL_RD1, 16'hA5A5, "reg5 after edge");
    reg_write = 1'b0; wr_data = 16'h5555;
    @(posedge clk); #1;
    expect_out(SEL_RD1, 16'hA5A5, "reg5 unchanged with reg_write=0 (port1)");
    expect_out(SEL_RD2, 16'hA5A5, "reg5 unchanged with reg_write=0 (port2)");

    // Register 0
    @(negedge clk);
    reg_write = 1'b1; wr_addr = 3'd0; wr_data = 16'h1234;
    @(posedge clk); #1;
    reg_write = 1'b0; rd_addr_1 = 3'd0;
    #1;
    expect_out(SEL_RD1, R0_EXP, "reg0 after write");

    // Memory store then loads (aliasing via bit 0 and wrap)
    @(negedge clk);
    mem_we = 1'b1; mem_addr = 16'h0006; mem_wdata = 16'hBEEF;
    @(posedge clk); #1;
    mem_we = 1'b0; mem_re = 1'b1;
    #1;
    expect_out(SEL_MEM, 16'hBEEF, "load 0x0006");
    mem_addr = 16'h0007; #1;
    expect_out(SEL_MEM, 16'hBEEF, "load 0x0007");
    mem_addr = 16'h0016; #1;
    expect_out(SEL_MEM, 16'hBEEF, "load 0x0016 wrap");
    mem_addr = 16'h0004; #1;
    expect_out(SEL_MEM, 16'h0000, "load 0x0004 untouched");
    mem_addr = 16'h0006; mem_re = 1'b0; #1;
    expect_out(SEL_MEM, 16'h0000, "mem_re=0");

    // Simultaneous write and read at the same word
    @(negedge clk);
    mem_we = 1'b1; mem_re = 1'b1; mem_addr = 16'h0006; mem_wdata = 16'h0F0F;
    #1;
    expect_out(SEL_MEM, 16'hBEEF, "we+re before edge");
    @(posedge clk); #1;
    expect_out(SEL_MEM, 16'h0F0F, "we+re after edge");
    mem_we = 1'b0;

    // Fill registers and memory, then reset asynchronously with writes held
    for (int i = 0; i < 8; i++) write_both(3'(i), 16'h1000 + 16'(i), 16'(2 * i), 16'h2000 + 16'(i));
    rd_addr_1 = 3'd3; mem_addr = 16'h000A; mem_re = 1'b1;
    #1;
    expect_out(SEL_RD1, 16'h1003, "reg3 filled");
    expect_out(SEL_MEM, 16'h2005, "mem[5] filled");
    @(negedge clk);
    #2;
    reg_write = 1'b1; wr_addr = 3'd3; wr_data = 16'hFFFF;
    mem_we = 1'b1; mem_addr = 16'h000A; mem_wdata = 16'hFFFF;
    rst_n = 1'b0;
    #1;
    expect_out(SEL_RD1, 16'h0000, "reg3 async clear");
    expect_out(SEL_MEM, 16'h0000, "mem[5] async clear");
    @(posedge clk); #1;
    expect_out(SEL_RD1, 16'h0000, "reg3 write ignored in reset");
    expect_out(SEL_MEM, 16'h0000, "mem[5] write ignored in reset");
    @(negedge clk);
    reg_write = 1'b0; mem_we = 1'b0;
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd_addr_1 = 3'(a); rd_addr_2 = 3'(a); mem_addr = 16'(2 * a);
      #1;
      expect_out(SEL_RD1, 16'h0000, $sformatf("post-reset reg[%0d]", a));
      expect_out(SEL_MEM, 16'h0000, $sformatf("post-reset mem[%0d]", a));
    end

    // Bounded drain of the scoreboard
    t = 0;
    while (sb_q.size() > 0 && t < 100) begin
      #1;
      t++;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
